// File: rtl/sram_dp_be.sv
// Simple dual-port SRAM with per-byte write enables, 1- or 2-cycle read latency,
// and a post-reset clear sequence. Optional per-lane parity is enabled by SRAM_PARITY_EN.
//
// state    | meaning
// ST_CLEAR | zeroing word[cnt] each cycle, init_busy high, ports ignored
// ST_READY | normal read/write operation
module sram_dp_be #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 4,
  parameter int    READ_LATENCY   = 1,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
`ifdef SRAM_PARITY_EN
  input  logic                    wr_parity_flip,
  output logic                    rd_parity_err,
`endif
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sram_dp_be: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("sram_dp_be: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic {ST_CLEAR, ST_READY} state_e;
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_READY;
      end
      ST_READY: ;
      default:  state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Defined during reset even before the first clock edge has loaded state_q.
  assign init_busy = rst ? (CLEAR_ON_RESET != 0) : (state_q == ST_CLEAR);

  logic clr_act, wr_act, rd_act, same_addr;
  assign clr_act   = !rst && (state_q == ST_CLEAR);
  assign wr_act    = !rst && (state_q == ST_READY) && wr_en;
  assign rd_act    = !rst && (state_q == ST_READY) && rd_en;
  assign same_addr = wr_act && (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (clr_act) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_act) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Write-first per lane: enabled lanes of a colliding write bypass the array.
  logic [DATA_WIDTH-1:0] rd_word;
  always_comb begin
    rd_word = mem_q[rd_addr];
    for (int i = 0; i < NB; i++) begin
      if (same_addr && wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  logic                  stage_valid;
  logic [DATA_WIDTH-1:0] stage_data;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= rd_act;
        if (rd_act) s1_data_q <= rd_word;
      end
    end
    assign stage_valid = s1_valid_q;
    assign stage_data  = s1_data_q;
  end else begin : g_lat1
    assign stage_valid = rd_act;
    assign stage_data  = rd_word;
  end

  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= stage_valid;
      if (stage_valid) rd_data_q <= stage_data;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

`ifdef SRAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] wr_par, rd_par;
  logic          rd_err;

  always_comb begin
    rd_par = par_q[rd_addr];
    rd_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      wr_par[i] = (^wr_data[8*i +: 8]) ^ wr_parity_flip;
      if (same_addr && wr_be[i]) rd_par[i] = wr_par[i];
      if ((^rd_word[8*i +: 8]) != rd_par[i]) rd_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_act) begin
      par_q[cnt_q] <= '0;
    end else if (wr_act) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) par_q[wr_addr][i] <= wr_par[i];
      end
    end
  end

  logic stage_err;
  if (READ_LATENCY == 2) begin : g_err_lat2
    logic s1_err_q;
    always_ff @(posedge clk) begin
      if (rst) s1_err_q <= 1'b0;
      else     s1_err_q <= rd_act && rd_err;
    end
    assign stage_err = s1_err_q;
  end else begin : g_err_lat1
    assign stage_err = rd_act && rd_err;
  end

  logic rd_err_q;
  always_ff @(posedge clk) begin
    if (rst) rd_err_q <= 1'b0;
    else     rd_err_q <= stage_valid && stage_err;
  end
  assign rd_parity_err = rd_err_q;
`endif

endmodule

// File: tb/tb_sram_dp_be.sv
// Directed bench for sram_dp_be: one instance at READ_LATENCY=1 and one at 2,
// driven by the same stimulus; parity checks appear when SRAM_PARITY_EN is defined.
module tb_sram_dp_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr, wr_be;
  logic [31:0] wr_data;
  logic        busy1, busy2, valid1, valid2;
  logic [31:0] data1, data2;
`ifdef SRAM_PARITY_EN
  logic        wr_parity_flip;
  logic        perr1, perr2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rst(rst), .init_busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
`ifdef SRAM_PARITY_EN
    .wr_parity_flip(wr_parity_flip), .rd_parity_err(perr1),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data1), .rd_valid(valid1)
  );

  sram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut2 (
    .clk(clk), .rst(rst), .init_busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
`ifdef SRAM_PARITY_EN
    .wr_parity_flip(wr_parity_flip), .rd_parity_err(perr2),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data2), .rd_valid(valid2)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a read and an ignored write active while busy; both must be suppressed.
  task automatic count_busy(input string tag);
    int n = 0;
    rd_en = 1'b1; rd_addr = 4'd5;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    while (busy1 === 1'b1 && n < 100) begin
      n++;
      chk({tag, " valid1 while busy"}, 32'(valid1), 32'd0);
      chk({tag, " valid2 while busy"}, 32'(valid2), 32'd0);
      tick();
    end
    rd_en = 1'b0; wr_en = 1'b0;
    chk({tag, " busy cycles"}, 32'(n), 32'd16);
    chk({tag, " busy2 fell together"}, 32'(busy2), 32'd0);
    repeat (2) begin
      chk({tag, " valid1 after busy"}, 32'(valid1), 32'd0);
      chk({tag, " valid2 after busy"}, 32'(valid2), 32'd0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
`ifdef SRAM_PARITY_EN
    wr_parity_flip = 1'b0;
`endif

    vecs[0]  = '{1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd5,  32'h0000_0000};
    vecs[1]  = '{1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'd0,  32'h0};
    vecs[2]  = '{1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd3,  32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 4'd3, 32'h1122_3344, 4'h5, 1'b0, 4'd0,  32'h0};
    vecs[4]  = '{1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd3,  32'hDE22_BE44};
    vecs[5]  = '{1'b1, 4'd3, 32'hFFFF_FFFF, 4'h0, 1'b0, 4'd0,  32'h0};
    vecs[6]  = '{1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd3,  32'hDE22_BE44};
    vecs[7]  = '{1'b1, 4'd7, 32'hA5A5_A5A5, 4'hF, 1'b1, 4'd7,  32'hA5A5_A5A5};
    vecs[8]  = '{1'b1, 4'd7, 32'h1234_5678, 4'hF, 1'b0, 4'd0,  32'h0};
    vecs[9]  = '{1'b1, 4'd7, 32'hA5A5_A5A5, 4'h3, 1'b1, 4'd7,  32'h1234_A5A5};
    vecs[10] = '{1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd7,  32'h1234_A5A5};
    vecs[11] = '{1'b1, 4'd9, 32'hCAFE_F00D, 4'hF, 1'b1, 4'd3,  32'hDE22_BE44};
    vecs[12] = '{1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd15, 32'h0000_0000};

    // Power-on reset and full clear.
    repeat (2) tick();
    chk("busy1 in reset", 32'(busy1), 32'd1);
    chk("busy2 in reset", 32'(busy2), 32'd1);
    chk("valid1 in reset", 32'(valid1), 32'd0);
    chk("data2 in reset", data2, 32'd0);
    rst = 1'b0;
    count_busy("por");

    // Reset once, then again when the clear counter has reached 8.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (8) tick();
    chk("busy1 mid clear", 32'(busy1), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    count_busy("mid-clear");

    for (int k = 0; k < NVEC; k++) begin
      wr_en = vecs[k].we; wr_addr = vecs[k].wa; wr_data = vecs[k].wd; wr_be = vecs[k].be;
      rd_en = vecs[k].re; rd_addr = vecs[k].ra;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk($sformatf("v%0d valid1", k), 32'(valid1), 32'(vecs[k].re));
      chk($sformatf("v%0d valid2 early", k), 32'(valid2), 32'd0);
      if (vecs[k].re) chk($sformatf("v%0d data1", k), data1, vecs[k].exp);
`ifdef SRAM_PARITY_EN
      if (vecs[k].re) chk($sformatf("v%0d perr1", k), 32'(perr1), 32'd0);
`endif
      tick();
      chk($sformatf("v%0d valid1 pulse", k), 32'(valid1), 32'd0);
      chk($sformatf("v%0d valid2", k), 32'(valid2), 32'(vecs[k].re));
      if (vecs[k].re) chk($sformatf("v%0d data2", k), data2, vecs[k].exp);
      if (vecs[k].re) chk($sformatf("v%0d data1 hold", k), data1, vecs[k].exp);
      tick();
      chk($sformatf("v%0d valid2 pulse", k), 32'(valid2), 32'd0);
      if (vecs[k].re) chk($sformatf("v%0d data2 hold", k), data2, vecs[k].exp);
    end

    // Back-to-back reads on three consecutive cycles.
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    chk("b2b valid1 a", 32'(valid1), 32'd1);
    chk("b2b data1 a", data1, 32'hDE22_BE44);
    rd_addr = 4'd7;
    tick();
    chk("b2b data1 b", data1, 32'h1234_A5A5);
    chk("b2b valid2 a", 32'(valid2), 32'd1);
    chk("b2b data2 a", data2, 32'hDE22_BE44);
    rd_addr = 4'd9;
    tick();
    rd_en = 1'b0;
    chk("b2b valid1 c", 32'(valid1), 32'd1);
    chk("b2b data1 c", data1, 32'hCAFE_F00D);
    chk("b2b data2 b", data2, 32'h1234_A5A5);
    tick();
    chk("b2b valid1 end", 32'(valid1), 32'd0);
    chk("b2b valid2 c", 32'(valid2), 32'd1);
    chk("b2b data2 c", data2, 32'hCAFE_F00D);
    tick();
    chk("b2b valid2 end", 32'(valid2), 32'd0);

`ifdef SRAM_PARITY_EN
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h0F0F_0F0F; wr_be = 4'hF; wr_parity_flip = 1'b1;
    tick();
    wr_en = 1'b0; wr_parity_flip = 1'b0;
    rd_en = 1'b1; rd_addr = 4'd2;
    tick();
    rd_en = 1'b0;
    chk("par flip data1", data1, 32'h0F0F_0F0F);
    chk("par flip perr1", 32'(perr1), 32'd1);
    tick();
    chk("par flip perr1 drop", 32'(perr1), 32'd0);
    chk("par flip perr2", 32'(perr2), 32'd1);
    chk("par flip data2", data2, 32'h0F0F_0F0F);
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    chk("par clean perr1", 32'(perr1), 32'd0);
    tick();
    chk("par clean perr2", 32'(perr2), 32'd0);
    chk("par clean data2", data2, 32'hDE22_BE44);
    tick();
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h0000_0001; wr_be = 4'h1; wr_parity_flip = 1'b1;
    rd_en = 1'b1; rd_addr = 4'd4;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; wr_parity_flip = 1'b0;
    chk("par bypass data1", data1, 32'h0000_0001);
    chk("par bypass perr1", 32'(perr1), 32'd1);
    tick();
    chk("par bypass perr2", 32'(perr2), 32'd1);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
